// File: rtl/jsv_sdram_pkg.sv
// rtl/jsv_sdram_pkg.sv - shared types and constants for the jsv_sdram arbiter slice
package jsv_sdram_pkg;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
    typedef enum logic {GNT_DISP, GNT_COMP} gnt_t;

    localparam int DEF_ADDR_W = 23;
    localparam int DEF_DATA_W = 16;
    localparam int DEF_BE_W   = 2;

    localparam logic [15:0] ABORT_DATA = 16'hDEAD;

endpackage

// File: rtl/jsv_sdram_wdog.sv
// rtl/jsv_sdram_wdog.sv - clear/enable/expire cycle counter; TIMEOUT=0 never expires
module jsv_sdram_wdog #(
    parameter int TIMEOUT = 1023
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    input  logic i_en,
    output logic o_expire
);

    generate
        if (TIMEOUT == 0) begin : g_bypass
            logic w_unused;
            assign w_unused = ^{i_clk, i_rst_n, i_clear, i_en};
            assign o_expire = 1'b0;
        end else begin : g_cnt
            localparam int CW = $clog2(TIMEOUT + 1);
            logic [CW-1:0] r_cnt;

            // Expire fires in the TIMEOUT-th enabled cycle, so the counter only needs to reach TIMEOUT-1.
            assign o_expire = i_en && (r_cnt == CW'(TIMEOUT - 1));

            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    r_cnt <= '0;
                end else if (i_clear) begin
                    r_cnt <= '0;
                end else if (i_en && !o_expire) begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/jsv_sdram_arbiter.sv
// rtl/jsv_sdram_arbiter.sv - DISP/COMP arbiter in front of the jsv_sdram bridge port
// Optional COMP starvation guard: JSV_ARB_STARVE_GUARD_EN
module jsv_sdram_arbiter
    import jsv_sdram_pkg::*;
#(
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int BE_W         = DEF_BE_W,
`ifdef JSV_ARB_STARVE_GUARD_EN
    parameter int STARVE_LIMIT = 8,
`endif
    parameter int TIMEOUT      = 1023
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    input  logic [ADDR_W-1:0] disp_address,
    input  logic              disp_read,
    output logic              disp_acknowledge,
    output logic [DATA_W-1:0] disp_read_data,
    input  logic [ADDR_W-1:0] comp_address,
    input  logic [BE_W-1:0]   comp_byte_enable,
    input  logic              comp_read,
    input  logic              comp_write,
    input  logic [DATA_W-1:0] comp_write_data,
    output logic              comp_acknowledge,
    output logic [DATA_W-1:0] comp_read_data,
    output logic [ADDR_W-1:0] bridge_0_ext_address,
    output logic [BE_W-1:0]   bridge_0_ext_byte_enable,
    output logic              bridge_0_ext_read,
    output logic              bridge_0_ext_write,
    output logic [DATA_W-1:0] bridge_0_ext_write_data,
    input  logic              bridge_0_ext_acknowledge,
    input  logic [DATA_W-1:0] bridge_0_ext_read_data,
    output logic              timeout_err
);

    state_t            r_state;
    gnt_t              r_gnt;
    logic [ADDR_W-1:0] r_addr;
    logic [BE_W-1:0]   r_be;
    logic [DATA_W-1:0] r_wdata;
    logic              r_rd;
    logic              r_wr;
    logic              r_disp_ack;
    logic              r_comp_ack;
    logic [DATA_W-1:0] r_disp_rdata;
    logic [DATA_W-1:0] r_comp_rdata;
    logic              r_terr;

    logic w_comp_req;
    logic w_any_req;
    logic w_sel_comp;
    logic w_expire;

    assign w_comp_req = comp_read | comp_write;
    assign w_any_req  = disp_read | w_comp_req;

`ifdef JSV_ARB_STARVE_GUARD_EN
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    logic [SW-1:0] r_starve;
    logic          w_force;

    assign w_force    = (r_starve >= SW'(STARVE_LIMIT));
    assign w_sel_comp = w_comp_req & (~disp_read | w_force);

    // Only IDLE cycles matter: a DISP grant over a waiting COMP counts, anything else resets.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_starve <= '0;
        end else if (r_state == IDLE) begin
            if (!w_comp_req || w_sel_comp) begin
                r_starve <= '0;
            end else if (r_starve < SW'(STARVE_LIMIT)) begin
                r_starve <= r_starve + 1'b1;
            end
        end
    end
`else
    assign w_sel_comp = w_comp_req & ~disp_read;
`endif

    jsv_sdram_wdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .i_clk    (clk_clk),
        .i_rst_n  (reset_reset_n),
        .i_clear  (r_state != BUSY),
        .i_en     (r_state == BUSY),
        .o_expire (w_expire)
    );

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_state      <= IDLE;
            r_gnt        <= GNT_DISP;
            r_addr       <= '0;
            r_be         <= '0;
            r_wdata      <= '0;
            r_rd         <= 1'b0;
            r_wr         <= 1'b0;
            r_disp_ack   <= 1'b0;
            r_comp_ack   <= 1'b0;
            r_disp_rdata <= '0;
            r_comp_rdata <= '0;
            r_terr       <= 1'b0;
        end else begin
            r_disp_ack <= 1'b0;
            r_comp_ack <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_any_req) begin
                        r_state <= BUSY;
                        if (w_sel_comp) begin
                            r_gnt   <= GNT_COMP;
                            r_addr  <= comp_address;
                            r_be    <= comp_write ? comp_byte_enable : '1;
                            r_wdata <= comp_write_data;
                            r_wr    <= comp_write;
                            r_rd    <= ~comp_write;
                        end else begin
                            r_gnt   <= GNT_DISP;
                            r_addr  <= disp_address;
                            r_be    <= '1;
                            r_wr    <= 1'b0;
                            r_rd    <= 1'b1;
                        end
                    end
                end
                BUSY: begin
                    // A bridge ack in the expiry cycle still completes normally.
                    if (bridge_0_ext_acknowledge || w_expire) begin
                        r_rd    <= 1'b0;
                        r_wr    <= 1'b0;
                        r_state <= RESP;
                        if (r_gnt == GNT_COMP) begin
                            r_comp_ack <= 1'b1;
                        end else begin
                            r_disp_ack <= 1'b1;
                        end
                        if (!bridge_0_ext_acknowledge) begin
                            r_terr <= 1'b1;
                            if (r_gnt == GNT_COMP) begin
                                r_comp_rdata <= DATA_W'(ABORT_DATA);
                            end else begin
                                r_disp_rdata <= DATA_W'(ABORT_DATA);
                            end
                        end else if (r_rd) begin
                            if (r_gnt == GNT_COMP) begin
                                r_comp_rdata <= bridge_0_ext_read_data;
                            end else begin
                                r_disp_rdata <= bridge_0_ext_read_data;
                            end
                        end
                    end
                end
                RESP: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign disp_acknowledge         = r_disp_ack;
    assign disp_read_data           = r_disp_rdata;
    assign comp_acknowledge         = r_comp_ack;
    assign comp_read_data           = r_comp_rdata;
    assign bridge_0_ext_address     = r_addr;
    assign bridge_0_ext_byte_enable = r_be;
    assign bridge_0_ext_read        = r_rd;
    assign bridge_0_ext_write       = r_wr;
    assign bridge_0_ext_write_data  = r_wdata;
    assign timeout_err              = r_terr;

endmodule

// File: tb/tb_jsv_sdram_arbiter.sv
// tb/tb_jsv_sdram_arbiter.sv - directed self-checking bench for jsv_sdram_arbiter (TIMEOUT=15)
module tb_jsv_sdram_arbiter;

    logic        clk_clk;
    logic        reset_reset_n;
    logic [22:0] disp_address;
    logic        disp_read;
    logic        disp_acknowledge;
    logic [15:0] disp_read_data;
    logic [22:0] comp_address;
    logic [1:0]  comp_byte_enable;
    logic        comp_read;
    logic        comp_write;
    logic [15:0] comp_write_data;
    logic        comp_acknowledge;
    logic [15:0] comp_read_data;
    logic [22:0] bridge_0_ext_address;
    logic [1:0]  bridge_0_ext_byte_enable;
    logic        bridge_0_ext_read;
    logic        bridge_0_ext_write;
    logic [15:0] bridge_0_ext_write_data;
    logic        bridge_0_ext_acknowledge;
    logic [15:0] bridge_0_ext_read_data;
    logic        timeout_err;

    jsv_sdram_arbiter #(
        .TIMEOUT (15)
    ) dut (
        .clk_clk                  (clk_clk),
        .reset_reset_n            (reset_reset_n),
        .disp_address             (disp_address),
        .disp_read                (disp_read),
        .disp_acknowledge         (disp_acknowledge),
        .disp_read_data           (disp_read_data),
        .comp_address             (comp_address),
        .comp_byte_enable         (comp_byte_enable),
        .comp_read                (comp_read),
        .comp_write               (comp_write),
        .comp_write_data          (comp_write_data),
        .comp_acknowledge         (comp_acknowledge),
        .comp_read_data           (comp_read_data),
        .bridge_0_ext_address     (bridge_0_ext_address),
        .bridge_0_ext_byte_enable (bridge_0_ext_byte_enable),
        .bridge_0_ext_read        (bridge_0_ext_read),
        .bridge_0_ext_write       (bridge_0_ext_write),
        .bridge_0_ext_write_data  (bridge_0_ext_write_data),
        .bridge_0_ext_acknowledge (bridge_0_ext_acknowledge),
        .bridge_0_ext_read_data   (bridge_0_ext_read_data),
        .timeout_err              (timeout_err)
    );

    initial clk_clk = 1'b0;
    always #5 clk_clk = ~clk_clk;

    int checks = 0;
    int errors = 0;

    logic [15:0] mem [int];
    int ack_delay = 1;
    bit ack_en    = 1'b1;
    int cmd_cnt   = 0;
    int n_wr, n_rd, n_dack, n_cack, n_overlap;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr_mon();
        n_wr = 0; n_rd = 0; n_dack = 0; n_cack = 0; n_overlap = 0;
    endtask

    // One clock: sample DUT after the edge, then play the bridge for this cycle.
    task automatic cycle();
        @(posedge clk_clk);
        #1;
        if (bridge_0_ext_write) n_wr++;
        if (bridge_0_ext_read) n_rd++;
        if (disp_acknowledge) n_dack++;
        if (comp_acknowledge) n_cack++;
        if ((disp_acknowledge || comp_acknowledge) && (bridge_0_ext_read || bridge_0_ext_write)) n_overlap++;
        if (bridge_0_ext_read || bridge_0_ext_write) begin
            cmd_cnt++;
            if (ack_en && cmd_cnt == ack_delay) begin
                bridge_0_ext_acknowledge = 1'b1;
                if (bridge_0_ext_write) begin
                    mem[int'(bridge_0_ext_address)] = bridge_0_ext_write_data;
                end else begin
                    bridge_0_ext_read_data = mem.exists(int'(bridge_0_ext_address)) ?
                                             mem[int'(bridge_0_ext_address)] : 16'h0000;
                end
            end else begin
                bridge_0_ext_acknowledge = 1'b0;
            end
        end else begin
            cmd_cnt = 0;
            bridge_0_ext_acknowledge = 1'b0;
        end
    endtask

    task automatic wait_ack(input string tag, input bit comp, input int budget, output int n);
        bit got;
        n = 0;
        got = 1'b0;
        while (!got && n < budget) begin
            cycle();
            n++;
            got = comp ? comp_acknowledge : disp_acknowledge;
        end
        chk(tag, 32'(got), 32'd1);
    endtask

    int n;
    int dack_at;
    bit done;

    initial begin
        reset_reset_n            = 1'b0;
        disp_address             = '0;
        disp_read                = 1'b0;
        comp_address             = '0;
        comp_byte_enable         = 2'b00;
        comp_read                = 1'b0;
        comp_write               = 1'b0;
        comp_write_data          = '0;
        bridge_0_ext_acknowledge = 1'b0;
        bridge_0_ext_read_data   = '0;
        mem[0] = 16'h1111;
        mem[1] = 16'h2222;
        mem[2] = 16'h3333;
        mem[5] = 16'h5555;
        clr_mon();

        cycle();
        cycle();
        chk("rst_bread", 32'(bridge_0_ext_read), 32'd0);
        chk("rst_bwrite", 32'(bridge_0_ext_write), 32'd0);
        chk("rst_baddr", 32'(bridge_0_ext_address), 32'd0);
        chk("rst_dack", 32'(disp_acknowledge), 32'd0);
        chk("rst_cack", 32'(comp_acknowledge), 32'd0);
        chk("rst_crdata", 32'(comp_read_data), 32'd0);
        chk("rst_terr", 32'(timeout_err), 32'd0);
        reset_reset_n = 1'b1;
        cycle();

        // 1: COMP write, bridge acks in the 4th command cycle; then read back
        clr_mon();
        ack_delay        = 4;
        comp_address     = 23'h00_1234;
        comp_write_data  = 16'hBEEF;
        comp_byte_enable = 2'b11;
        comp_write       = 1'b1;
        cycle();
        chk("t1_bwrite", 32'(bridge_0_ext_write), 32'd1);
        chk("t1_bread", 32'(bridge_0_ext_read), 32'd0);
        chk("t1_baddr", 32'(bridge_0_ext_address), 32'h1234);
        chk("t1_bwdata", 32'(bridge_0_ext_write_data), 32'hBEEF);
        chk("t1_bbe", 32'(bridge_0_ext_byte_enable), 32'd3);
        wait_ack("t1_ack", 1'b1, 20, n);
        chk("t1_latency", 32'(n), 32'd4);
        chk("t1_wr_cycles", 32'(n_wr), 32'd4);
        comp_write = 1'b0;
        cycle();
        chk("t1_ack_1cyc", 32'(comp_acknowledge), 32'd0);
        ack_delay = 1;
        comp_read = 1'b1;
        wait_ack("t1_rd_ack", 1'b1, 20, n);
        chk("t1_rd_latency", 32'(n), 32'd2);
        chk("t1_rd_data", 32'(comp_read_data), 32'hBEEF);
        comp_read = 1'b0;
        cycle();
        chk("t1_rd_hold", 32'(comp_read_data), 32'hBEEF);

        // 2: simultaneous DISP read and COMP write, DISP first
        clr_mon();
        ack_delay       = 2;
        disp_address    = 23'd5;
        disp_read       = 1'b1;
        comp_address    = 23'd6;
        comp_write_data = 16'h6666;
        comp_write      = 1'b1;
        cycle();
        chk("t2_first_read", 32'(bridge_0_ext_read), 32'd1);
        chk("t2_first_addr", 32'(bridge_0_ext_address), 32'd5);
        wait_ack("t2_dack", 1'b0, 20, n);
        chk("t2_dlatency", 32'(n), 32'd2);
        chk("t2_ddata", 32'(disp_read_data), 32'h5555);
        chk("t2_no_wr_yet", 32'(n_wr), 32'd0);
        disp_read = 1'b0;
        wait_ack("t2_cack", 1'b1, 20, n);
        chk("t2_clatency", 32'(n), 32'd4);
        chk("t2_wr_cycles", 32'(n_wr), 32'd2);
        chk("t2_mem6", 32'(mem.exists(6) ? mem[6] : 16'h0000), 32'h6666);
        chk("t2_crdata_kept", 32'(comp_read_data), 32'hBEEF);
        comp_write = 1'b0;
        cycle();

        // 3: back-to-back DISP reads with immediate bridge ack
        clr_mon();
        ack_delay    = 1;
        disp_address = 23'd0;
        disp_read    = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wait_ack($sformatf("t3_ack%0d", i), 1'b0, 20, n);
            chk($sformatf("t3_lat%0d", i), 32'(n), (i == 0) ? 32'd2 : 32'd3);
            chk($sformatf("t3_data%0d", i), 32'(disp_read_data), 32'h1111 * 32'(i + 1));
            disp_address = 23'(i + 1);
            if (i == 2) disp_read = 1'b0;
        end
        cycle();
        chk("t3_dack_cycles", 32'(n_dack), 32'd3);
        chk("t3_rd_cycles", 32'(n_rd), 32'd3);
        chk("t3_overlap", 32'(n_overlap), 32'd0);
        chk("t3_dack_low", 32'(disp_acknowledge), 32'd0);

        // 4: bridge never acks, watchdog aborts after 15 BUSY cycles
        clr_mon();
        ack_en       = 1'b0;
        comp_address = 23'd7;
        comp_read    = 1'b1;
        wait_ack("t4_ack", 1'b1, 40, n);
        chk("t4_latency", 32'(n), 32'd16);
        chk("t4_rd_cycles", 32'(n_rd), 32'd15);
        chk("t4_dead", 32'(comp_read_data), 32'hDEAD);
        chk("t4_terr", 32'(timeout_err), 32'd1);
        chk("t4_bread_low", 32'(bridge_0_ext_read), 32'd0);
        comp_read = 1'b0;
        ack_en    = 1'b1;
        cycle();
        cycle();
        chk("t4_terr_sticky", 32'(timeout_err), 32'd1);

        // 5: continuous DISP reads with a pending COMP write
        clr_mon();
        disp_address    = 23'd0;
        disp_read       = 1'b1;
        comp_address    = 23'd9;
        comp_write_data = 16'h9999;
        comp_write      = 1'b1;
        done    = 1'b0;
        dack_at = -1;
        for (int i = 0; i < 60 && !done; i++) begin
            cycle();
            if (comp_acknowledge) begin
                done    = 1'b1;
                dack_at = n_dack;
            end
        end
`ifdef JSV_ARB_STARVE_GUARD_EN
        chk("t5_comp_granted", 32'(done), 32'd1);
        chk("t5_disp_before", 32'(dack_at), 32'd8);
        chk("t5_mem9", 32'(mem.exists(9) ? mem[9] : 16'h0000), 32'h9999);
`else
        chk("t5_comp_granted", 32'(done), 32'd0);
        chk("t5_no_write", 32'(n_wr), 32'd0);
        chk("t5_disp_count", 32'(n_dack), 32'd20);
`endif
        comp_write = 1'b0;
        disp_read  = 1'b0;
        for (int i = 0; i < 6; i++) cycle();

        // 6: reset pulsed mid-BUSY
        clr_mon();
        ack_en       = 1'b0;
        disp_address = 23'd2;
        disp_read    = 1'b1;
        cycle();
        chk("t6_cmd", 32'(bridge_0_ext_read), 32'd1);
        cycle();
        #2;
        reset_reset_n = 1'b0;
        #1;
        chk("t6_bread_async", 32'(bridge_0_ext_read), 32'd0);
        chk("t6_baddr_async", 32'(bridge_0_ext_address), 32'd0);
        chk("t6_terr_cleared", 32'(timeout_err), 32'd0);
        disp_read = 1'b0;
        cycle();
        cycle();
        reset_reset_n = 1'b1;
        ack_en        = 1'b1;
        cycle();
        chk("t6_no_ack", 32'(n_dack + n_cack), 32'd0);
        comp_address = 23'h00_1234;
        comp_read    = 1'b1;
        cycle();
        chk("t6_idle_grant", 32'(bridge_0_ext_read), 32'd1);
        chk("t6_idle_addr", 32'(bridge_0_ext_address), 32'h1234);
        wait_ack("t6_ack", 1'b1, 20, n);
        chk("t6_latency", 32'(n), 32'd1);
        chk("t6_data", 32'(comp_read_data), 32'hBEEF);
        comp_read = 1'b0;
        cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
